prio_enc_rr: RTL
================

Name: prio_enc_rr

Overview:
- Parametrised, registered successor to the fixed 8-to-3 MSB priority encoder.
- Encodes an N-bit request vector into a binary index plus a one-hot grant.
- Three run-time priority modes: fixed MSB-first, fixed LSB-first, and round-robin with an internal pointer.
- Result sits in an output register with a valid/ready handshake, so the block feeds arbitration and interrupt-select paths directly.

Parameters:
- N, 8, number of request lines (N >= 2; need not be a power of two).
- W, $clog2(N), index width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mode  in  2  priority mode: 00 MSB-first, 01 LSB-first, 10 round-robin, 11 reserved (behaves as 00).
- req  in  N  request vector; bit k requests index k.
- out_ready  in  1  downstream accepts the registered result.
- out_valid  out  1  registered result holds at least one request.
- out_idx  out  W  encoded index of the granted request.
- out_onehot  out  N  one-hot grant; equals 1<<out_idx when out_valid, else 0.

Behaviour:
- Reset:
  - rst_n sampled low at a clock edge gives out_valid=0, out_idx=0, out_onehot=0 and ptr=0.
  - Any held result is discarded.
  - Reset has priority over every other event.
- Load condition: load = !out_valid || out_ready. Evaluated every cycle.
- On load:
  - out_valid <= |req.
  - out_idx and out_onehot <= the combinational grant for the current req and mode.
  - If req==0: out_idx <= 0 and out_onehot <= 0.
- Latency: one cycle from req to registered result. There is no combinational path from req to the outputs.
- Hold (out_valid && !out_ready): all outputs and ptr stay frozen, and req changes are ignored.
- MSB mode: grant goes to the highest set index.
- LSB mode: grant goes to the lowest set index.
- Round-robin mode:
  - Grant goes to the lowest set index >= ptr. If there is none, it wraps to the lowest set index overall.
  - On a load with |req: ptr <= (idx==N-1) ? 0 : idx+1.
  - ptr does not change on a load with req==0.
- Pointer in other modes:
  - ptr does not change in the fixed modes.
  - ptr is retained across mode changes, so switching back to RR resumes fairness.
- Mode sampling: mode is sampled only on load cycles. A mode change during hold affects the next load only.
- Non-power-of-two N:
  - ptr and idx never exceed N-1.
  - Wrap goes from N-1 to 0.
- Simultaneous out_ready=1 and a new req: the current result is consumed and the new result is loaded in the same edge (back-to-back throughput of 1 per cycle).
- Invariants:
  - out_onehot has exactly one bit set iff out_valid.
  - out_onehot[out_idx]==1 when out_valid.

Decomposition:
- Shared package: mode encodings MODE_MSB=2'b00, MODE_LSB=2'b01, MODE_RR=2'b10.
- Sub-module prio_enc_core: combinational, parametrised N-bit LSB-first encoder returning idx and found.
  - MSB mode: instantiate it on bit-reversed req, and map the result back as idx = N-1-idx.
  - RR mode: two instances, one on req masked to bits >= ptr and one on unmasked req. Take the masked result if found, else the unmasked result.
  - The parent holds the output register, ptr and handshake.

Test Plan:
1. rst_n=0 for 3 cycles with req=8'hFF, mode=10 -> out_valid=0, out_idx=0, out_onehot=0 every cycle. First RR grant after release is idx 0.
2. mode=00, req=8'b0010_0110, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_onehot=8'h20. Then req=0 -> next cycle out_valid=0, out_onehot=0.
3. mode=01, same req -> out_idx=1, out_onehot=8'h02. mode=11, same req -> out_idx=5 (treated as MSB).
4. mode=10, req=8'hFF held, out_ready=1 -> out_idx sequence 0,1,2,3,4,5,6,7,0. Then req=8'h81 -> sequence alternates 0,7,0,7.
5. mode=10, out_ready=0 for 4 cycles while out_valid=1 and req toggles randomly -> out_idx, out_onehot and ptr unchanged. Raise out_ready -> next load uses current req and ptr = held idx+1.
6. N=5, mode=10, req=5'b10001 -> grants 0,4,0,4, with ptr wrapping from 4 to 0. rst_n=0 mid-hold -> out_valid=0 next cycle and ptr=0.

Source files
------------

// File: rtl/prio_enc_rr_pkg.sv
// Shared definitions for the registered round-robin priority encoder.
// Mode encodings are common to RTL and bench.
package prio_enc_rr_pkg;

    typedef enum logic [1:0] {
        MODE_MSB = 2'b00,
        MODE_LSB = 2'b01,
        MODE_RR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

endpackage

// File: rtl/prio_enc_rr_if.sv
// Request/result bundle for prio_enc_rr.
// The slave side is the encoder; the master side drives requests.
interface prio_enc_rr_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [1:0]   mode;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    modport slave (
        input  mode,
        input  req,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot
    );

    modport master (
        output mode,
        output req,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot
    );
endinterface

// File: rtl/prio_enc_core.sv
// Combinational LSB-first encoder: lowest set bit index plus found flag.
// idx is 0 when nothing is set.
module prio_enc_core #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-way priority encoder: MSB, LSB or round-robin grant,
// held in an output register behind a valid/ready handshake.
module prio_enc_rr #(
    parameter int N = 8
) (
    input logic          clk,
    input logic          rst_n,
    prio_enc_rr_if.slave bus
);
    import prio_enc_rr_pkg::*;

    localparam int W = $clog2(N);

    logic [N-1:0] req_rev;
    logic [N-1:0] req_msk;
    logic [W-1:0] idx_all;
    logic [W-1:0] idx_rev;
    logic [W-1:0] idx_msk;
    logic         fnd_all;
    logic         fnd_rev;
    logic         fnd_msk;

    logic [W-1:0] gnt_idx;
    logic         gnt_fnd;
    logic         is_rr;
    logic         is_lsb;
    logic         load;

    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] oh_q, oh_d;

    // MSB search reuses the LSB core on a reversed vector; RR masks below ptr
    always_comb begin
        req_rev = '0;
        req_msk = '0;
        for (int i = 0; i < N; i++) begin
            req_rev[i] = bus.req[N-1-i];
            req_msk[i] = bus.req[i] && (i >= int'(ptr_q));
        end
    end

    prio_enc_core #(.N(N)) u_all (
        .req_i   (bus.req),
        .idx_o   (idx_all),
        .found_o (fnd_all)
    );

    prio_enc_core #(.N(N)) u_rev (
        .req_i   (req_rev),
        .idx_o   (idx_rev),
        .found_o (fnd_rev)
    );

    prio_enc_core #(.N(N)) u_msk (
        .req_i   (req_msk),
        .idx_o   (idx_msk),
        .found_o (fnd_msk)
    );

    assign is_rr  = (bus.mode == MODE_RR);
    assign is_lsb = (bus.mode == MODE_LSB);

    always_comb begin
        gnt_idx = '0;
        gnt_fnd = 1'b0;
        unique case (1'b1)
            is_rr: begin
                gnt_fnd = fnd_all;
                gnt_idx = fnd_msk ? idx_msk : idx_all;
            end
            is_lsb: begin
                gnt_fnd = fnd_all;
                gnt_idx = idx_all;
            end
            default: begin
                gnt_fnd = fnd_rev;
                gnt_idx = W'(N - 1) - idx_rev;
            end
        endcase
    end

    assign load = !valid_q || bus.out_ready;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = gnt_fnd;
            idx_d   = gnt_fnd ? gnt_idx : '0;
            oh_d    = gnt_fnd ? (N'(1) << gnt_idx) : '0;
            if (is_rr && gnt_fnd) begin
                ptr_d = (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            oh_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = oh_q;

endmodule
